regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file for the RV32 core, with a second write port for the load writeback path.
- Configurable read-port count.
- Optional same-cycle write-to-read bypass.
- Per-register load scoreboard that flags operands whose load result has not yet returned.
- Sits between decode (reads, load issue) and writeback (ALU and load writes); drives the decode stall.

Parameters:
WIDTH, 32, data width in bits
NUMREGS, 32, register count; 2..32; address width fixed at 5 bits
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle forwarding of write data to read ports; 0 = reads see array contents only

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
alu_wr_en  in  1  ALU writeback enable
alu_rd  in  5  ALU destination register
alu_result  in  WIDTH  ALU writeback data
ld_wr_en  in  1  load writeback enable
ld_rd  in  5  load destination register
ld_data  in  WIDTH  load writeback data
issue_ld_valid  in  1  a load is issued this cycle
issue_ld_rd  in  5  destination register of the issued load
rs_valid  in  NRD  per-port read request
rs_addr  in  NRD*5  per-port source address, port i at bits [5i+4:5i]
src_value  out  NRD*WIDTH  per-port operand, port i at bits [WIDTH*i+WIDTH-1:WIDTH*i]
src_ready  out  NRD  per-port operand valid (no outstanding load)
stall  out  1  OR of ~src_ready across all ports
pending_cnt  out  6  number of registers with an outstanding load

Behaviour:
Reset (reset=0, asynchronous):
- All registers and all pending bits clear to 0.
- Resulting outputs: src_value=0, src_ready all 1, stall=0, pending_cnt=0.
- Reset asserted mid-operation drops every outstanding load; no write occurs on that edge.

Writes (registered on the rising edge, when reset=1):
- alu_wr_en writes alu_result to alu_rd.
- ld_wr_en writes ld_data to ld_rd.
- Register 0 is never written; addresses >= NUMREGS are ignored.
- Both ports target the same register in one cycle: ALU data wins (younger instruction).

Scoreboard (registered):
- issue_ld_valid with issue_ld_rd != 0 sets pending[issue_ld_rd].
- ld_wr_en clears pending[ld_rd].
- Set and clear of the same register in one cycle: set wins (new load outstanding).
- An ALU write does not change any pending bit.
- pending_cnt is the registered popcount of the pending bits, updated in the same edge as the bits.

Reads (combinational, per port i):
- rs_valid[i]=0 or rs_addr=0: value 0, ready 1.
- Otherwise, with BYPASS=1, value is selected in this priority order:
  - alu_wr_en and alu_rd matches: alu_result
  - ld_wr_en and ld_rd matches: ld_data
  - otherwise: array contents
- With BYPASS=0, value is the array contents.
- src_ready[i] = !pending[rs] or (BYPASS and ld_wr_en and ld_rd==rs).
- A load issued in the same cycle does not affect ready until the next cycle.
- rs_valid is compared 2-state (X is treated as 0).
- Read latency is 0 cycles; write-to-array latency is 1 cycle.

Decomposition:
- Package regfile_pkg holds REG_ADDR_W=5, the default WIDTH/NUMREGS, and the reg_addr_t typedef.
- Sub-module rf_read_port (one instance per read port, generate loop) holds the bypass mux and ready logic.
- The array and scoreboard stay in the top module.

Test Plan:
- Reset, then read x5 on both ports -> src_value 0, src_ready 2'b11, stall 0, pending_cnt 0.
- alu_wr_en x5=0xDEADBEEF; same cycle read x5 (BYPASS=1) -> 0xDEADBEEF; BYPASS=0 -> 0 that cycle, 0xDEADBEEF the next.
- issue_ld x7; next cycle read x7 -> src_ready 0, stall 1, pending_cnt 1; ld_wr_en x7=0x1234 same cycle -> src_ready 1, value 0x1234; one cycle later pending_cnt 0.
- Same cycle: alu x3=0xA, ld x3=0xB -> read x3 gives 0xA (bypass and array).
- Same cycle: ld_wr_en x9 and issue_ld x9 -> x9 still pending next cycle; write to x0 -> reads stay 0; issue_ld x0 -> pending_cnt unchanged.
- Three loads outstanding (x1, x2, x3), then assert reset mid-stream -> pending_cnt 0, all registers 0, stall 0 immediately, no clock edge required.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file with load scoreboard.
package regfile_pkg;
    localparam int REG_ADDR_W  = 5;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NUMREGS = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/rf_read_port.sv
// One register file read port: write-to-read bypass selection and operand ready.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter bit BYPASS = 1'b1
) (
    input  logic                  rs_valid,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [WIDTH-1:0]      array_value,
    input  logic                  pending,
    input  logic                  alu_wr_en,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  ld_wr_en,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [WIDTH-1:0]      ld_data,
    output logic [WIDTH-1:0]      src_value,
    output logic                  src_ready
);

    logic alu_hit;
    logic ld_hit;

    assign alu_hit = alu_wr_en && (alu_rd == rs_addr);
    assign ld_hit  = ld_wr_en && (ld_rd == rs_addr);

    // An X on rs_valid falls to the idle branch, so it reads as "no request".
    always_comb begin
        src_value = '0;
        src_ready = 1'b1;
        if (rs_valid && (rs_addr != '0)) begin
            if (BYPASS && alu_hit) begin
                src_value = alu_result;
            end else if (BYPASS && ld_hit) begin
                src_value = ld_data;
            end else begin
                src_value = array_value;
            end
            src_ready = !pending || (BYPASS && ld_hit);
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// RV32 integer register file: ALU and load write ports, NRD read ports, load scoreboard.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUMREGS = DEF_NUMREGS,
    parameter int NRD     = 2,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alu_wr_en,
    input  logic [REG_ADDR_W-1:0]     alu_rd,
    input  logic [WIDTH-1:0]          alu_result,
    input  logic                      ld_wr_en,
    input  logic [REG_ADDR_W-1:0]     ld_rd,
    input  logic [WIDTH-1:0]          ld_data,
    input  logic                      issue_ld_valid,
    input  logic [REG_ADDR_W-1:0]     issue_ld_rd,
    input  logic [NRD-1:0]            rs_valid,
    input  logic [NRD*REG_ADDR_W-1:0] rs_addr,
    output logic [NRD*WIDTH-1:0]      src_value,
    output logic [NRD-1:0]            src_ready,
    output logic                      stall,
    output logic [5:0]                pending_cnt
);

    localparam logic [REG_ADDR_W:0] NUMREGS_L = (REG_ADDR_W+1)'(NUMREGS);

    logic [WIDTH-1:0]   regs [NUMREGS];
    logic [NUMREGS-1:0] pending;
    logic [NUMREGS-1:0] pending_next;
    logic [5:0]         cnt_next;

    function automatic logic in_range(input reg_addr_t a);
        return {1'b0, a} < NUMREGS_L;
    endfunction

    // ALU write is applied last so it overrides a load to the same register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUMREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ld_wr_en && (ld_rd != '0) && in_range(ld_rd)) begin
                regs[ld_rd] <= ld_data;
            end
            if (alu_wr_en && (alu_rd != '0) && in_range(alu_rd)) begin
                regs[alu_rd] <= alu_result;
            end
        end
    end

    // A new load issue outranks a returning load on the same register.
    always_comb begin
        pending_next = pending;
        if (ld_wr_en && in_range(ld_rd)) begin
            pending_next[ld_rd] = 1'b0;
        end
        if (issue_ld_valid && (issue_ld_rd != '0) && in_range(issue_ld_rd)) begin
            pending_next[issue_ld_rd] = 1'b1;
        end
        cnt_next = '0;
        for (int i = 0; i < NUMREGS; i++) begin
            cnt_next = cnt_next + 6'(pending_next[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_next;
            pending_cnt <= cnt_next;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_port
        reg_addr_t        addr;
        logic [WIDTH-1:0] arr_val;
        logic             pend;

        assign addr    = rs_addr[REG_ADDR_W*i +: REG_ADDR_W];
        assign arr_val = in_range(addr) ? regs[addr] : '0;
        assign pend    = in_range(addr) && pending[addr];

        rf_read_port #(
            .WIDTH  (WIDTH),
            .BYPASS (BYPASS)
        ) u_port (
            .rs_valid    (rs_valid[i]),
            .rs_addr     (addr),
            .array_value (arr_val),
            .pending     (pend),
            .alu_wr_en   (alu_wr_en),
            .alu_rd      (alu_rd),
            .alu_result  (alu_result),
            .ld_wr_en    (ld_wr_en),
            .ld_rd       (ld_rd),
            .ld_data     (ld_data),
            .src_value   (src_value[WIDTH*i +: WIDTH]),
            .src_ready   (src_ready[i])
        );
    end

    assign stall = ~&src_ready;

endmodule
